// File: rtl/dm_responder.sv
// Data-memory responder: single-cycle stores and loads with programmable latency over a REQ/ACK handshake.
// Optional `DM_BYTE_EN adds a per-byte store enable input 'be'.
module dm_responder #(
  parameter int AW  = 5,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  input  logic [AW-1:0] a,
  input  logic [31:0]   wd,
  input  logic          we,
  input  logic          re,
`ifdef DM_BYTE_EN
  input  logic [3:0]    be,
`endif
  output logic          ack,
  output logic          busy,
  output logic [31:0]   rd,
  output logic          rvalid,
  output logic          wdone
);

  generate
    if (LAT < 1 || LAT > 8) begin : g_bad_lat
      $error("dm_responder: LAT must be within 1..8");
    end
  endgenerate

  localparam logic [2:0] CntInit = 3'((LAT >= 2) ? (LAT - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT       state;
  stateT       nextState;
  logic [31:0] mem [2**AW];
  logic [31:0] loadBuf;
  logic [2:0]  latCnt;
  logic        accStore;
  logic        accLoad;

  assign busy     = (state != IDLE);
  assign ack      = req & ~busy;
  assign rvalid   = (state == RESP);
  assign accStore = ack & we;
  assign accLoad  = ack & re & ~we;

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accLoad) nextState = (LAT == 1) ? RESP : WAIT;
      WAIT:    if (latCnt == 3'd0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // rd is loaded on the edge entering RESP so it is already valid while rvalid is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      latCnt  <= 3'd0;
      loadBuf <= 32'd0;
      rd      <= 32'd0;
      wdone   <= 1'b0;
    end else begin
      state <= nextState;
      wdone <= accStore;
      if (accLoad) begin
        loadBuf <= mem[a];
        latCnt  <= CntInit;
      end else if (state == WAIT && latCnt != 3'd0) begin
        latCnt <= latCnt - 3'd1;
      end
      if (nextState == RESP)
        rd <= (state == IDLE) ? mem[a] : loadBuf;
    end
  end

  // Memory has no reset so contents survive rst
  always_ff @(posedge clk) begin
    if (accStore) begin
`ifdef DM_BYTE_EN
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[a][8*i +: 8] <= wd[8*i +: 8];
`else
      mem[a] <= wd;
`endif
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: five instances with different load latencies share one
// stimulus stream and are each checked every cycle against a cycle-count reference model.
module tb_dm_responder;

  localparam int N  = 5;
  localparam int AW = 5;
  localparam int LATS [N] = '{1, 2, 3, 4, 8};
`ifdef DM_BYTE_EN
  localparam bit BeOn = 1'b1;
`else
  localparam bit BeOn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic          re;
  logic [AW-1:0] a;
  logic [31:0]   wd;
  logic [3:0]    stimBe;
`ifdef DM_BYTE_EN
  logic [3:0]    be;
  assign be = stimBe;
`endif

  logic        ack    [N];
  logic        busy   [N];
  logic        rvalid [N];
  logic        wdone  [N];
  logic [31:0] rd     [N];

  logic [31:0] mMem      [N][2**AW];
  int          mBusyLeft [N];
  logic [31:0] mPend     [N];
  logic [31:0] mLastRd   [N];
  logic        mWdone    [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  generate
    for (genvar k = 0; k < N; k++) begin : g_dut
      dm_responder #(.AW(AW), .LAT(LATS[k])) u_dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .a      (a),
        .wd     (wd),
        .we     (we),
        .re     (re),
`ifdef DM_BYTE_EN
        .be     (be),
`endif
        .ack    (ack[k]),
        .busy   (busy[k]),
        .rd     (rd[k]),
        .rvalid (rvalid[k]),
        .wdone  (wdone[k])
      );
    end
  endgenerate

  task automatic check32(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s dut%0d(LAT=%0d) observed=%h expected=%h", tag, k, LATS[k], obs, exp);
    end
  endtask

  // Expected outputs follow from how many busy cycles remain after an accepted load
  task automatic checkOutput();
    logic eBusy, eRvalid;
    for (int k = 0; k < N; k++) begin
      eBusy   = (mBusyLeft[k] > 0);
      eRvalid = (mBusyLeft[k] == 1);
      check32("busy",   k, {31'd0, busy[k]},   {31'd0, eBusy});
      check32("ack",    k, {31'd0, ack[k]},    {31'd0, req & ~eBusy});
      check32("rvalid", k, {31'd0, rvalid[k]}, {31'd0, eRvalid});
      check32("wdone",  k, {31'd0, wdone[k]},  {31'd0, mWdone[k]});
      check32("rd",     k, rd[k], eRvalid ? mPend[k] : mLastRd[k]);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < N; k++) begin
      mBusyLeft[k] = 0;
      mLastRd[k]   = 32'd0;
      mWdone[k]    = 1'b0;
    end
  endtask

  task automatic modelEdge();
    logic [3:0] mask;
    mask = BeOn ? stimBe : 4'hF;
    for (int k = 0; k < N; k++) begin
      mWdone[k] = 1'b0;
      if (mBusyLeft[k] > 0) begin
        if (mBusyLeft[k] == 1) mLastRd[k] = mPend[k];
        mBusyLeft[k]--;
      end else if (req) begin
        if (we) begin
          for (int b = 0; b < 4; b++)
            if (mask[b]) mMem[k][a][8*b +: 8] = wd[8*b +: 8];
          mWdone[k] = 1'b1;
        end else if (re) begin
          mPend[k]     = mMem[k][a];
          mBusyLeft[k] = LATS[k];
        end
      end
    end
  endtask

  // Drive one cycle of inputs at the falling edge, check, then advance the model across the rising edge
  task automatic applyStimulus(input logic r, input logic w, input logic l,
                               input logic [AW-1:0] ad, input logic [31:0] d, input logic [3:0] bIn);
    req = r; we = w; re = l; a = ad; wd = d; stimBe = bIn;
    #1;
    checkOutput();
    @(posedge clk);
    if (rst) modelReset(); else modelEdge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0, 32'd0, 4'hF);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; re = 1'b0; a = '0; wd = '0; stimBe = 4'hF;
    modelReset();
    @(negedge clk);
    #1;
    checkOutput();
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] filling memory with back-to-back stores");
    for (int i = 0; i < 2**AW; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(i), $urandom, 4'hF);
    idle(1);

    $display("[TB] store then load of address 3");
    applyStimulus(1'b1, 1'b1, 1'b0, AW'(3), 32'hDEADBEEF, 4'hF);
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(3), 32'd0, 4'hF);
    idle(9);
    for (int k = 0; k < N; k++) check32("rd_deadbeef", k, rd[k], 32'hDEADBEEF);

    $display("[TB] store with WE and RE both high");
    applyStimulus(1'b1, 1'b1, 1'b1, AW'(7), 32'h12345678, 4'hF);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(7), 32'd0, 4'hF);
    idle(9);

    $display("[TB] load held high across busy periods");
    for (int i = 0; i < 24; i++)
      applyStimulus(1'b1, 1'b0, 1'b1, AW'(3), 32'd0, 4'hF);
    idle(9);

    $display("[TB] consecutive loads and consecutive stores");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b1, AW'(i), 32'd0, 4'hF);
    idle(9);
    for (int i = 8; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, AW'(i), $urandom, 4'hF);

    if (BeOn) begin
      $display("[TB] partial byte store");
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(5), 32'hAABBCCDD, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(5), 32'h11223344, 4'b0101);
      applyStimulus(1'b1, 1'b1, 1'b0, AW'(6), 32'h55667788, 4'b0000);
      applyStimulus(1'b1, 1'b0, 1'b1, AW'(5), 32'd0, 4'b0000);
      idle(9);
      for (int k = 0; k < N; k++) check32("rd_byte_en", k, rd[k], 32'hAA22CC44);
    end

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++)
      applyStimulus(($urandom % 4) != 0, $urandom % 2, $urandom % 2,
                    AW'($urandom), $urandom, 4'($urandom));
    idle(9);

    $display("[TB] reset during a pending load");
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(9), 32'd0, 4'hF);
    idle(2);
    #3;
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput();
    @(negedge clk);
    idle(3);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b1, AW'(11), 32'd0, 4'hF);
    idle(9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
